// File: rtl/sum_pkg.sv
// Shared types and constants for the serial-adder arbiter and its datapath.
package sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Wide enough to hold a count that runs 0..reglength.
    function automatic int cnt_width(input int reglength);
        return $clog2(reglength + 1);
    endfunction

endpackage

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first: operand shift registers, carry flop and result
// shift register filled from the MSB end.
module serial_adder #(
    parameter int reglength = 3
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 step,
    input  logic [reglength-1:0] a_in,
    input  logic [reglength-1:0] b_in,
    output logic [reglength:0]   sum_next
);

    logic [reglength-1:0] a_reg;
    logic [reglength-1:0] b_reg;
    logic [reglength-1:0] res_reg;
    logic [reglength-1:0] res_shift;
    logic                 c_reg;
    logic                 s_bit;
    logic                 c_next;

    assign s_bit  = a_reg[0] ^ b_reg[0] ^ c_reg;
    assign c_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);

    // Result register shifts right; the new sum bit enters at the MSB.
    generate
        for (genvar gi = 0; gi < reglength - 1; gi++) begin : g_res_shift
            assign res_shift[gi] = res_reg[gi+1];
        end
    endgenerate
    assign res_shift[reglength-1] = s_bit;

    // Full sum as it will look once the current bit has been stepped in.
    assign sum_next = {c_next, res_shift};

    always_ff @(posedge clk) begin
        if (clr) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            c_reg   <= 1'b0;
        end else if (load) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            res_reg <= '0;
            c_reg   <= 1'b0;
        end else if (step) begin
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            res_reg <= res_shift;
            c_reg   <= c_next;
        end
    end

endmodule

// File: rtl/sum_arbiter.sv
// Round-robin controller that shares one serial_adder between two requesters
// and returns a registered (reglength+1)-bit sum with a one-cycle done strobe.
module sum_arbiter
    import sum_pkg::*;
#(
    parameter int reglength = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic [reglength-1:0] a0,
    input  logic [reglength-1:0] b0,
    input  logic                 req1,
    input  logic [reglength-1:0] a1,
    input  logic [reglength-1:0] b1,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic [1:0]           done,
    output logic [reglength:0]   sum
);

    localparam int CW = cnt_width(reglength);

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 last_reg, last_next;
    logic [1:0]           grant_reg, grant_next;
    logic [1:0]           done_reg, done_next;
    logic [reglength:0]   sum_reg, sum_next;
    logic [reglength:0]   sum_calc;
    logic [reglength-1:0] a_sel;
    logic [reglength-1:0] b_sel;
    logic                 pick;
    logic                 load;
    logic                 step;
    logic                 final_bit;

    // On a tie the requester that was not served last wins.
    assign pick      = (req0 && req1) ? ((last_reg == REQ0) ? REQ1 : REQ0)
                                      : (req1 ? REQ1 : REQ0);
    assign a_sel     = (pick == REQ1) ? a1 : a0;
    assign b_sel     = (pick == REQ1) ? b1 : b0;
    assign final_bit = (cnt_reg == CW'(reglength - 1));

    serial_adder #(.reglength(reglength)) u_adder (
        .clk      (clk),
        .clr      (reset),
        .load     (load),
        .step     (step),
        .a_in     (a_sel),
        .b_in     (b_sel),
        .sum_next (sum_calc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= REQ1;
            grant_reg <= 2'b00;
            done_reg  <= 2'b00;
            sum_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
            grant_reg <= grant_next;
            done_reg  <= done_next;
            sum_reg   <= sum_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req0 || req1) state_next = ADD;
            ADD:     if (final_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load       = 1'b0;
        step       = 1'b0;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        grant_next = grant_reg;
        done_next  = 2'b00;
        sum_next   = sum_reg;
        case (state_reg)
            IDLE: begin
                grant_next = 2'b00;
                if (req0 || req1) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    last_next  = pick;
                    grant_next = (pick == REQ1) ? 2'b10 : 2'b01;
                end
            end
            ADD: begin
                step     = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (final_bit) begin
                    sum_next  = sum_calc;
                    done_next = (last_reg == REQ1) ? 2'b10 : 2'b01;
                end
            end
            DONE: begin
                grant_next = 2'b00;
            end
            default: begin
                grant_next = 2'b00;
            end
        endcase
    end

    assign grant = grant_reg;
    assign done  = done_reg;
    assign sum   = sum_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_sum_arbiter.sv
// Directed self-checking bench for sum_arbiter with reglength = 3.
module tb_sum_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [2:0] a0, b0, a1, b1;
    logic [1:0] grant, done;
    logic       busy;
    logic [3:0] sum;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sum_arbiter #(.reglength(3)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .grant (grant),
        .busy  (busy),
        .done  (done),
        .sum   (sum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic [1:0] g, input logic [1:0] d,
                              input logic bz, input logic [3:0] s);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_done"},  32'(done),  32'(d));
        check({tag, "_busy"},  32'(busy),  32'(bz));
        check({tag, "_sum"},   32'(sum),   32'(s));
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // One transaction through requester r, started from IDLE; checks latency and result.
    task automatic op(input logic r, input int a, input int b);
        int lat = 0;
        if (r) begin req1 = 1'b1; a1 = 3'(a); b1 = 3'(b); end
        else   begin req0 = 1'b1; a0 = 3'(a); b0 = 3'(b); end
        while (done == 2'b00 && lat < 10) begin
            tick();
            lat++;
        end
        check("sweep_lat", 32'(lat), 32'd4);
        check("sweep_done", 32'(done), r ? 32'd2 : 32'd1);
        check("sweep_sum", 32'(sum), 32'(a + b));
        $display("op req%0d a=%0d b=%0d sum=%0d lat=%0d", r, a, b, sum, lat);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check("sweep_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
        a0 = 3'd1; b0 = 3'd2; a1 = 3'd3; b1 = 3'd4;

        // Reset held with both requests high
        tick(); check_outs("rst1", 2'b00, 2'b00, 1'b0, 4'd0);
        tick(); check_outs("rst2", 2'b00, 2'b00, 1'b0, 4'd0);
        reset = 1'b0;
        tick(); check("rst_first_grant", 32'(grant), 32'd1);
        $display("reset: first grant=%0d", grant);
        do_reset();

        // Single request 3 + 5
        req0 = 1'b1; a0 = 3'd3; b0 = 3'd5;
        tick(); check_outs("single_e0", 2'b01, 2'b00, 1'b1, 4'd0);
        tick(); tick();
        check("single_e2_done", 32'(done), 32'd0);
        tick(); check_outs("single_e3", 2'b01, 2'b01, 1'b1, 4'd8);
        req0 = 1'b0;
        tick(); check_outs("single_e4", 2'b00, 2'b00, 1'b0, 4'd8);
        $display("single: sum=%0d", sum);

        // Tie, then round-robin hand-over to requester 1
        do_reset();
        req0 = 1'b1; req1 = 1'b1; a0 = 3'd7; b0 = 3'd7; a1 = 3'd0; b1 = 3'd1;
        tick(); check("tie_e0_grant", 32'(grant), 32'd1);
        tick(); tick();
        tick(); check_outs("tie_e3", 2'b01, 2'b01, 1'b1, 4'd14);
        req0 = 1'b0;
        tick(); check("tie_e4_grant", 32'(grant), 32'd0);
        tick(); check("tie_e5_grant", 32'(grant), 32'd2);
        tick(); tick();
        tick(); check_outs("tie_e8", 2'b10, 2'b10, 1'b1, 4'd1);
        req1 = 1'b0;
        tick(); check_outs("tie_e9", 2'b00, 2'b00, 1'b0, 4'd1);
        $display("tie: second sum=%0d", sum);

        // Operands and request changed after grant are ignored
        req1 = 1'b1; a1 = 3'd6; b1 = 3'd2;
        tick(); check("indep_e0_grant", 32'(grant), 32'd2);
        tick();
        a1 = 3'd1; b1 = 3'd1; req1 = 1'b0;
        tick();
        tick(); check_outs("indep_e3", 2'b10, 2'b10, 1'b1, 4'd8);
        tick();
        $display("indep: sum=%0d", sum);

        // Reset in the middle of an operation
        do_reset();
        req0 = 1'b1; a0 = 3'd7; b0 = 3'd1;
        tick(); check("midrst_e0_grant", 32'(grant), 32'd1);
        tick();
        reset = 1'b1;
        tick(); check_outs("midrst_e2", 2'b00, 2'b00, 1'b0, 4'd0);
        reset = 1'b0;
        tick(); check_outs("midrst_e3", 2'b01, 2'b00, 1'b1, 4'd0);
        tick(); check("midrst_e4_done", 32'(done), 32'd0);
        tick(); check("midrst_e5_done", 32'(done), 32'd0);
        tick(); check_outs("midrst_e6", 2'b01, 2'b01, 1'b1, 4'd8);
        req0 = 1'b0;
        tick();
        $display("midrst: regrant sum=%0d", sum);

        // Exhaustive sweep, every third pair through requester 1
        for (int i = 0; i < 64; i++) begin
            op((i % 3) == 0, i / 8, i % 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sum_arbiter.md
# sum_arbiter

Shares one bit-serial adder between two requesters. Each requester presents two `reglength`-bit operands and a request, and receives a one-cycle completion strobe with a `reglength+1`-bit sum. The adder processes one bit per clock, LSB first. The block sequences the adder's operand loading, bit stepping and result capture, and arbitrates round-robin between requesters. It sits in front of the summator datapath as its controller.

## Interface
- `reglength`, default 3: operand width in bits; must be ≥ 1.

- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req0`  in  1: request from requester 0.
- `a0`  in  `reglength`: operand A of requester 0.
- `b0`  in  `reglength`: operand B of requester 0.
- `req1`  in  1: request from requester 1.
- `a1`  in  `reglength`: operand A of requester 1.
- `b1`  in  `reglength`: operand B of requester 1.
- `grant`  out  2: one-hot owner of the adder; `00` when idle.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  2: one-cycle pulse on the owner's bit when the sum is valid.
- `sum`  out  `reglength+1`: result `{carry, bits}`; updated only when `done` pulses, held otherwise.

## Operation
- **States:** IDLE, ADD, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester that is not `last` (round-robin pointer).
  - On grant: latch that requester's a/b into shift registers, clear carry and bit counter, set `grant`, update `last`, go to ADD.
- **ADD**
  - Each cycle: `s = a[0]^b[0]^c`, `c = maj(a[0], b[0], c)`.
  - Shift a and b right; shift `s` into the result register from the MSB end.
  - Counter runs 0..`reglength-1`. On the final bit, register `sum = {c_next, bits}`, assert `done[owner]`, go to DONE.
- **DONE:** clear `done` and `grant`; go to IDLE.
- **Operand latching:** operands are latched once, at grant. Input changes after grant are ignored.
- **Early req drop:** `req` deasserted before `done` is ignored; the operation completes and `done` still pulses.
- **Request hold:** a requester holds `req` until it sees `done`. If `req` is still high in IDLE afterwards, it is a new request.
  - With both pending, round-robin prevents starvation.
- **Arithmetic:** unsigned, no overflow. `sum` max is `2*(2^reglength-1)`.

## Timing
- Edge E0: IDLE samples a request. `grant`/`busy` become high after E0.
- Edges E1..E`reglength`: one bit each. `done` and new `sum` are visible after E`reglength`.
  - Latency from request sampled to `done` is `reglength` cycles after grant.
- After E`reglength+1`: `done`=0, `grant`=00, `busy`=0, state IDLE.
- Earliest next grant is after E`reglength+2`. Occupancy is `reglength+2` cycles per operation.
- **Reset values:** state IDLE, `grant`=00, `done`=00, `busy`=0, `sum`=0, `last`=1 (requester 0 wins the first tie), carry/counter/shift registers 0.
- **Reset mid-operation:** abort at that edge. No `done` is issued, `sum` is cleared, and pending requests are re-arbitrated from the reset state.
- **Reset and request on the same edge:** reset wins; the request is sampled no earlier than the next edge.

## Structure
- Shared package `sum_pkg`:
  - State enum `{IDLE, ADD, DONE}`.
  - Requester-index constants `REQ0` and `REQ1`.
  - Counter-width expression `$clog2(reglength+1)`.
- One sub-module `serial_adder`:
  - Holds the operand shift registers, carry flop and result shift register.
  - Controls: `load`, `step`, `clr`.
- The arbiter/FSM stays in `sum_arbiter`.

## Test plan
All scenarios use `reglength`=3.
1. **Reset:** assert `reset` for 2 cycles with both requests high → `grant`=00, `done`=00, `busy`=0, `sum`=0 throughout. First grant appears after the edge following reset release.
2. **Single request:** `req0`=1, a0=3, b0=5 → `grant`=01 after E0. `done`=01 and `sum`=8 (1000b) after E3; `grant`=00 after E4.
3. **Tie and round-robin:** `req0`, `req1` both high; a0=b0=7, a1=0, b1=1; each requester keeps `req` high until its own `done` → requester 0 wins, `sum`=14 after E3. `grant`=10 after E5, `done`=10 with `sum`=1 after E8.
4. **Input independence:** `req1` with a1=6, b1=2; change a1/b1 and drop `req1` after E1 → `done`=10 with `sum`=8 regardless.
5. **Reset mid-operation:** `req0`, a0=7, b0=1; `reset` at E2 → no `done` pulse, `sum`=0, state IDLE. Still-high `req0` is granted after the first edge with `reset` low.
6. **Exhaustive sweep:** all 64 (a, b) pairs via `req0`, alternating some through `req1` → every `done` carries `sum`=a+b. No gaps other than the IDLE cycle.
